// File: rtl/sram8t_bist_if.sv
// ---------------------------------------------------------------------------
// sram8t_bist_if
// Bundles the two buses that meet at the BIST controller:
//   f_*      functional access port (cs/re/we/addr/din) from the system side
//   mem_*    SRAM macro pins (cs/re/we/addr/din) plus its registered dout
// Modports:
//   master : the BIST controller (reads f_* and mem_dout, drives mem_*)
//   slave  : the environment (drives f_* and mem_dout, observes mem_*)
// ---------------------------------------------------------------------------
interface sram8t_bist_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  f_cs;
    logic                  f_re;
    logic                  f_we;
    logic [ADDR_WIDTH-1:0] f_addr;
    logic [DATA_WIDTH-1:0] f_din;

    logic                  mem_cs;
    logic                  mem_re;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport master (
        input  f_cs, f_re, f_we, f_addr, f_din, mem_dout,
        output mem_cs, mem_re, mem_we, mem_addr, mem_din
    );

    modport slave (
        output f_cs, f_re, f_we, f_addr, f_din, mem_dout,
        input  mem_cs, mem_re, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/sram8t_bist.sv
// ---------------------------------------------------------------------------
// sram8t_bist
// March C- self-test controller owning the 8T SRAM macro pins. While idle or
// done it passes the functional port straight through to the macro; while
// running it sequences the six March C- elements, compares the macro's
// registered read data and stops at the first mismatch.
// Ports:
//   clk, rst_n   clock shared with the SRAM; asynchronous active-low reset
//   start        single-cycle run request (accepted in IDLE or DONE only)
//   bus          sram8t_bist_if.master: f_* functional port in, mem_* out,
//                mem_dout in
//   busy         test in progress
//   done         test finished, held until the next accepted start
//   fail         mismatch found (valid while done)
//   fail_addr    address of the first mismatch
//   fail_elem    March element (0-5) of the first mismatch
//   fail_data    mem_dout captured at the first mismatch
// ---------------------------------------------------------------------------
module sram8t_bist #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    sram8t_bist_if.master         bus,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_ISSUE,
        S_RD_CHECK,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
    localparam logic [2:0]            LAST_ELEM = 3'd5;

    // March C- element table:
    //   0 U w0 | 1 U r0,w1 | 2 U r1,w0 | 3 D r0,w1 | 4 D r1,w0 | 5 U r0
    function automatic logic elem_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic elem_read_bg(input logic [2:0] e);
        return (e == 3'd2) || (e == 3'd4);
    endfunction

    function automatic logic elem_write_bg(input logic [2:0] e);
        return (e == 3'd1) || (e == 3'd3);
    endfunction

    function automatic logic elem_single_op(input logic [2:0] e);
        return (e == 3'd0) || (e == LAST_ELEM);
    endfunction

    state_t                state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic                  op_q, op_d;       // 0: first op of element, 1: the trailing write
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  fail_q, fail_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]            fail_elem_q, fail_elem_d;
    logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;

    logic                  last_op;
    logic                  addr_end;
    logic [2:0]            elem_next;
    logic [DATA_WIDTH-1:0] rd_expect;

    assign last_op   = elem_single_op(elem_q) || op_q;
    // End of element is a compare against the sweep's final address, not a wrap test.
    assign addr_end  = elem_down(elem_q) ? (addr_q == '0) : (addr_q == ADDR_MAX);
    assign elem_next = elem_q + 3'd1;
    assign rd_expect = {DATA_WIDTH{elem_read_bg(elem_q)}};

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            state_q     <= S_IDLE;
            elem_q      <= '0;
            op_q        <= 1'b0;
            addr_q      <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_data_q <= fail_data_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned and infers a latch.
        state_d     = state_q;
        elem_d      = elem_q;
        op_d        = op_q;
        addr_d      = addr_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        fail_data_d = fail_data_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_WR;
                    elem_d      = '0;
                    op_d        = 1'b0;
                    addr_d      = '0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_elem_d = '0;
                    fail_data_d = '0;
                end
            end

            S_RD_ISSUE: state_d = S_RD_CHECK;

            S_WR, S_RD_CHECK: begin
                if (state_q == S_RD_CHECK && bus.mem_dout != rd_expect) begin
                    state_d     = S_DONE;
                    fail_d      = 1'b1;
                    fail_addr_d = addr_q;
                    fail_elem_d = elem_q;
                    fail_data_d = bus.mem_dout;
                end else if (!last_op) begin
                    // Only elements 1-4 have a second op, and it is always a write.
                    op_d    = 1'b1;
                    state_d = S_WR;
                end else if (!addr_end) begin
                    op_d    = 1'b0;
                    addr_d  = elem_down(elem_q) ? addr_q - 1'b1 : addr_q + 1'b1;
                    state_d = (elem_q == 3'd0) ? S_WR : S_RD_ISSUE;
                end else if (elem_q == LAST_ELEM) begin
                    state_d = S_DONE;
                end else begin
                    // Every element after 0 opens with a read.
                    elem_d  = elem_next;
                    op_d    = 1'b0;
                    addr_d  = elem_down(elem_next) ? ADDR_MAX : '0;
                    state_d = S_RD_ISSUE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- SRAM pin mux ----------------
    always_comb begin
        bus.mem_cs   = bus.f_cs;
        bus.mem_re   = bus.f_re;
        bus.mem_we   = bus.f_we;
        bus.mem_addr = bus.f_addr;
        bus.mem_din  = bus.f_din;

        unique case (state_q)
            S_WR: begin
                bus.mem_cs   = 1'b1;
                bus.mem_re   = 1'b0;
                bus.mem_we   = 1'b1;
                bus.mem_addr = addr_q;
                bus.mem_din  = {DATA_WIDTH{elem_write_bg(elem_q)}};
            end
            S_RD_ISSUE: begin
                bus.mem_cs   = 1'b1;
                bus.mem_re   = 1'b1;
                bus.mem_we   = 1'b0;
                bus.mem_addr = addr_q;
                bus.mem_din  = '0;
            end
            S_RD_CHECK: begin
                // Quiet cycle: the registered dout from RD_ISSUE is compared at its end.
                bus.mem_cs   = 1'b0;
                bus.mem_re   = 1'b0;
                bus.mem_we   = 1'b0;
                bus.mem_addr = addr_q;
                bus.mem_din  = '0;
            end
            default: ;
        endcase
    end

    // ---------------- status ----------------
    assign busy      = (state_q == S_WR) || (state_q == S_RD_ISSUE) || (state_q == S_RD_CHECK);
    assign done      = (state_q == S_DONE);
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
    assign fail_data = fail_data_q;

endmodule

// File: tb/tb_sram8t_bist.sv
// ---------------------------------------------------------------------------
// tb_sram8t_bist
// Bench for sram8t_bist: an 8T SRAM model with per-word stuck-at masks, a
// March C- reference that expands a run into the expected per-cycle SRAM
// access list and final status, one negedge compare process, and directed
// plus randomized scenarios with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_sram8t_bist;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic          cs;
        logic          re;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [DW-1:0] fail_data;

    sram8t_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram8t_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem),
        .fail_data (fail_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit rand_f  = 1'b0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- SRAM model with stuck-at faults ----------------
    logic [DW-1:0] sram [DEPTH];
    logic [DW-1:0] sa0 [DEPTH];   // bits forced to 0 on read
    logic [DW-1:0] sa1 [DEPTH];   // bits forced to 1 on read
    logic [DW-1:0] sram_dout;

    function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input int a);
        return (v | sa1[a]) & ~sa0[a];
    endfunction

    always @(posedge clk) begin
        if (bus.mem_cs && bus.mem_we) sram[bus.mem_addr] <= bus.mem_din;
        if (bus.mem_cs && bus.mem_re) sram_dout <= faulty(sram[bus.mem_addr], int'(bus.mem_addr));
    end
    assign bus.mem_dout = sram_dout;

    // ---------------- March C- reference ----------------
    // Per element: sweep direction, value read (-1 none) and value written (-1 none).
    int el_down [6] = '{0, 0, 0, 1, 1, 0};
    int el_rd   [6] = '{-1, 0, 1, 0, 1, 0};
    int el_wr   [6] = '{0, 1, 0, 1, 0, -1};

    rec_t          exp_q[$];
    logic [DW-1:0] mm [DEPTH];
    bit            r_fail;
    logic [AW-1:0] r_addr;
    logic [2:0]    r_elem;
    logic [DW-1:0] r_data;
    bit            m_done = 1'b0, m_fail = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [2:0]    m_elem = '0;
    logic [DW-1:0] m_data = '0;

    function automatic rec_t mk(input logic cs, input logic re, input logic we,
                                input int a, input logic [DW-1:0] d);
        rec_t r;
        r.cs = cs; r.re = re; r.we = we; r.addr = AW'(a); r.din = d;
        return r;
    endfunction

    task automatic build_run();
        int a;
        logic [DW-1:0] v, want;
        exp_q.delete();
        r_fail = 1'b0; r_addr = '0; r_elem = '0; r_data = '0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < DEPTH; k++) begin
                a = (el_down[e] != 0) ? DEPTH - 1 - k : k;
                if (el_rd[e] >= 0) begin
                    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, a, '0));
                    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, a, '0));
                    v    = faulty(mm[a], a);
                    want = (el_rd[e] != 0) ? '1 : '0;
                    if (v != want) begin
                        r_fail = 1'b1; r_addr = AW'(a); r_elem = 3'(e); r_data = v;
                        return;
                    end
                end
                if (el_wr[e] >= 0) begin
                    mm[a] = (el_wr[e] != 0) ? '1 : '0;
                    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, a, mm[a]));
                end
            end
        end
    endtask

    // One entry of exp_q is consumed per busy cycle; an empty queue means idle/done.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_done = 1'b0; m_fail = 1'b0; m_addr = '0; m_elem = '0; m_data = '0;
        end else if (exp_q.size() == 0) begin
            if (start) begin
                build_run();
                m_done = 1'b0; m_fail = 1'b0; m_addr = '0; m_elem = '0; m_data = '0;
            end
        end else begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
                m_done = 1'b1; m_fail = r_fail; m_addr = r_addr; m_elem = r_elem; m_data = r_data;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        rec_t r;
        if (chk_en) begin
            if (exp_q.size() != 0) begin
                r = exp_q[0];
                check("run_busy", busy, 1);
                check("run_done", done, 0);
                check("run_fail", fail, 0);
                check("run_cs", bus.mem_cs, r.cs);
                check("run_re", bus.mem_re, r.re);
                check("run_we", bus.mem_we, r.we);
                if (r.cs) check("run_addr", bus.mem_addr, r.addr);
                if (r.we) check("run_din", bus.mem_din, r.din);
            end else begin
                check("idle_busy", busy, 0);
                check("idle_done", done, m_done);
                check("idle_fail", fail, m_fail);
                check("idle_fail_addr", fail_addr, m_addr);
                check("idle_fail_elem", fail_elem, m_elem);
                check("idle_fail_data", fail_data, m_data);
                check("mux_cs", bus.mem_cs, bus.f_cs);
                check("mux_re", bus.mem_re, bus.f_re);
                check("mux_we", bus.mem_we, bus.f_we);
                check("mux_addr", bus.mem_addr, bus.f_addr);
                check("mux_din", bus.mem_din, bus.f_din);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_f) begin
            bus.f_cs   = 1'($urandom);
            bus.f_re   = 1'($urandom);
            bus.f_we   = 1'($urandom);
            bus.f_addr = AW'($urandom);
            bus.f_din  = DW'($urandom);
        end
    endtask

    task automatic f_idle();
        bus.f_cs = 1'b0; bus.f_re = 1'b0; bus.f_we = 1'b0; bus.f_addr = '0; bus.f_din = '0;
    endtask

    task automatic clear_faults();
        for (int i = 0; i < DEPTH; i++) begin
            sa0[i] = '0;
            sa1[i] = '0;
        end
    endtask

    // Pulses start, optionally re-pulses it at busy cycle extra_at, and
    // measures how long busy stays high.
    task automatic do_run(input bit lit, input int exp_len, input int extra_at, input bit efail,
                          input logic [AW-1:0] ea, input logic [2:0] ee, input logic [DW-1:0] ed);
        int cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_done_clear", done, 0);
        check("start_fail_clear", fail, 0);
        check("start_busy", busy, 1);
        cnt = 0;
        while (busy === 1'b1 && cnt < 2000) begin
            cnt++;
            start = (cnt == extra_at);
            tick();
        end
        start = 1'b0;
        check("end_done", done, 1);
        if (lit) begin
            check("busy_len", cnt, exp_len);
            check("end_fail", fail, efail);
            if (efail) begin
                check("fail_addr", fail_addr, ea);
                check("fail_elem", fail_elem, ee);
                check("fail_data", fail_data, ed);
            end
        end else if (cnt >= 2000) begin
            check("busy_timeout", cnt, 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        clear_faults();
        f_idle();
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_fail_addr", fail_addr, 0);
        check("rst_fail_elem", fail_elem, 0);
        check("rst_fail_data", fail_data, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();

        // Functional passthrough: write 0xA5 to address 3, read it back.
        bus.f_cs = 1'b1; bus.f_we = 1'b1; bus.f_re = 1'b0; bus.f_addr = 4'd3; bus.f_din = 8'hA5;
        #1;
        check("pt_we", bus.mem_we, 1);
        check("pt_addr", bus.mem_addr, 3);
        check("pt_din", bus.mem_din, 8'hA5);
        tick();
        bus.f_we = 1'b0; bus.f_re = 1'b1; bus.f_din = 8'h00;
        tick();
        f_idle();
        check("pt_dout", bus.mem_dout, 8'hA5);

        // Good memory; a second start at busy cycle 50 must be ignored.
        rand_f = 1'b1;
        do_run(1'b1, 240, 50, 1'b0, '0, '0, '0);
        rand_f = 1'b0;
        f_idle();
        tick();
        bus.f_cs = 1'b1; bus.f_re = 1'b1; bus.f_addr = 4'd5;
        tick();
        f_idle();
        check("post_run_dout", bus.mem_dout, 8'h00);

        // Start again from DONE with a good memory.
        rand_f = 1'b1;
        do_run(1'b1, 240, 0, 1'b0, '0, '0, '0);

        // Address 9 bit 3 stuck-at-1: caught by element 1 r0 after 16+27+2 cycles.
        sa1[9] = 8'h08;
        do_run(1'b1, 45, 20, 1'b1, 4'h9, 3'd1, 8'h08);
        clear_faults();

        // Address 2 bit 0 stuck-at-0: caught by element 2 r1 after 16+48+6+2 cycles.
        sa0[2] = 8'h01;
        do_run(1'b1, 72, 30, 1'b1, 4'h2, 3'd2, 8'hFE);
        clear_faults();

        // Restart from a failed DONE clears fail.
        do_run(1'b1, 240, 0, 1'b0, '0, '0, '0);

        // Random single stuck-at faults, checked by the compare process.
        for (int i = 0; i < 6; i++) begin
            int a, b;
            a = $urandom_range(0, DEPTH - 1);
            b = $urandom_range(0, DW - 1);
            if ($urandom_range(0, 1) == 1) sa1[a][b] = 1'b1;
            else                           sa0[a][b] = 1'b1;
            do_run(1'b0, 0, $urandom_range(1, 40), 1'b0, '0, '0, '0);
            check("rand_fault_detected", fail, 1);
            clear_faults();
        end

        // Reset at busy cycle 100 aborts with status cleared immediately.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (99) tick();
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_fail", fail, 0);
        check("arst_mux_we", bus.mem_we, bus.f_we);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);
        do_run(1'b1, 240, 0, 1'b0, '0, '0, '0);

        rand_f = 1'b0;
        repeat (3) tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
